comparator_monitor: RTL and testbench
=====================================

COMPARATOR_MONITOR -- requirements
Module: comparator_monitor

Interface
REQ-001 SHALL have parameter N_CH, default 4: number of comparator channels, range 1..16.
REQ-002 SHALL have parameter SYNC_STAGES, default 2: synchroniser depth, minimum 2.
REQ-003 SHALL have parameter DEB_W, default 8: debounce length width.
REQ-004 SHALL have parameter CNT_W, default 16: per-channel event counter width.
REQ-005 SHALL have port wb_clk_i  input  1: the single clock.
REQ-006 SHALL have port wb_rst_i  input  1: reset, asynchronous, active-high.
REQ-007 SHALL have port enable_i  input  1: monitor enable.
REQ-008 SHALL have port cmp_i  input  N_CH: raw comparator outputs, asynchronous to wb_clk_i.
REQ-009 SHALL have port deb_len_i  input  DEB_W: debounce length in cycles, common to all channels.
REQ-010 SHALL have port irq_mode_i  input  2*N_CH: per-channel mode, bits [2i+1:2i]; 00 off, 01 rising, 10 falling, 11 both.
REQ-011 SHALL have port clear_i  input  N_CH: per-channel clear of irq, count and overflow.
REQ-012 SHALL have port sel_i  input  max(1,$clog2(N_CH)): readback channel select.
REQ-013 SHALL have port cmp_o  output  N_CH: debounced comparator levels.
REQ-014 SHALL have port irq_o  output  N_CH: sticky per-channel event flags.
REQ-015 SHALL have port count_o  output  CNT_W: rising-edge count of channel sel_i, registered.
REQ-016 SHALL have port ovf_o  output  1: sticky overflow flag of channel sel_i, registered.

Function
REQ-017 Each cmp_i bit SHALL pass through SYNC_STAGES flops; the last stage is "synced".
REQ-018 Per channel, the debounce counter SHALL clear when synced equals cmp_o and increment when they differ.
REQ-019 When synced differs from cmp_o and the counter equals deb_len_i, cmp_o SHALL take synced at the next edge, and the counter SHALL clear.
REQ-020 Latency from a synced change held stable to the cmp_o change SHALL be deb_len_i+1 cycles; deb_len_i=0 gives 1 cycle.
REQ-021 A glitch on synced shorter than deb_len_i+1 cycles SHALL NOT change cmp_o.
REQ-022 A rising event SHALL occur on the cycle cmp_o goes 0->1; a falling event SHALL occur on 1->0.
REQ-023 irq_o[i] SHALL set on an event matching irq_mode_i[i] and hold until clear_i[i]; set SHALL win over a simultaneous clear.
REQ-024 Counter i SHALL increment on each rising event of channel i and saturate at all-ones.
REQ-025 An increment attempt at all-ones SHALL set overflow i (sticky).
REQ-026 clear_i[i] SHALL zero counter i and overflow i; clear SHALL win over a simultaneous rising event, and that event is not counted.
REQ-027 count_o and ovf_o SHALL reflect channel sel_i one cycle after sel_i is sampled.
REQ-028 sel_i >= N_CH SHALL yield count_o=0 and ovf_o=0.
REQ-029 With enable_i=0, debounce counters SHALL be held at 0, and cmp_o, counters, overflow and irq_o SHALL hold.
REQ-030 With enable_i=0, synchronisers and clear_i SHALL remain active.
REQ-031 A deb_len_i change mid-count SHALL take effect on the next compare, with no counter reset.

Reset
REQ-032 wb_rst_i high SHALL asynchronously zero all synchroniser stages, debounce counters, cmp_o, irq_o, event counters, overflow flags, count_o and ovf_o.
REQ-033 Reset mid-debounce SHALL discard the pending change; after release, the change SHALL require a full deb_len_i+1 stable cycles.
REQ-034 Reset release SHALL take effect on the first wb_clk_i edge after wb_rst_i falls.

Verification
REQ-035 Latency: N_CH=4, deb_len_i=3, enable_i=1, cmp_i[0] 0->1 held -> cmp_o[0]=1 exactly SYNC_STAGES+4 cycles later; irq_o[0]=1 with mode 01; count_o=1 with sel_i=0.
REQ-036 Glitch: deb_len_i=3, cmp_i[1] high for 3 cycles -> cmp_o[1], irq_o[1] and the count all remain 0.
REQ-037 Modes: mode 10 on channel 2, pulse 0->1->0 with each level held 10 cycles at deb_len_i=0 -> irq_o[2] set only after the falling event; count=1.
REQ-038 Saturation: CNT_W=4, 17 rising events on channel 3 -> count_o=15 and ovf_o=1; then clear_i[3] -> count_o=0 and ovf_o=0.
REQ-039 Simultaneous events: clear_i[0] asserted on the rising-event cycle -> irq_o[0]=1 and count 0.
REQ-040 Enable and reset: enable_i=0 during a toggle -> cmp_o holds; wb_rst_i pulsed mid-debounce -> all outputs 0 immediately, with no stale change after release.

Source files
------------

// File: rtl/comparator_monitor.sv
// Comparator monitor: synchronise, debounce, edge-detect and count N_CH
// asynchronous comparator inputs, with sticky irqs and per-channel readback.
//
// Ports:
//   wb_clk_i    clock
//   wb_rst_i    asynchronous active-high reset
//   enable_i    monitor enable (synchronisers and clears stay live when low)
//   cmp_i       raw comparator levels, asynchronous to wb_clk_i
//   deb_len_i   debounce length; a level must be stable deb_len_i+1 cycles
//   irq_mode_i  per channel [2i+1:2i]: 00 off, 01 rise, 10 fall, 11 both
//   clear_i     per channel clear of irq, event count and overflow
//   sel_i       readback channel select
//   cmp_o       debounced levels
//   irq_o       sticky event flags
//   count_o     registered rising-edge count of channel sel_i
//   ovf_o       registered sticky overflow of channel sel_i
module comparator_monitor #(
  parameter int N_CH        = 4,
  parameter int SYNC_STAGES = 2,
  parameter int DEB_W       = 8,
  parameter int CNT_W       = 16,
  localparam int SEL_W      = (N_CH > 1) ? $clog2(N_CH) : 1
) (
  input  logic              wb_clk_i,
  input  logic              wb_rst_i,
  input  logic              enable_i,
  input  logic [N_CH-1:0]   cmp_i,
  input  logic [DEB_W-1:0]  deb_len_i,
  input  logic [2*N_CH-1:0] irq_mode_i,
  input  logic [N_CH-1:0]   clear_i,
  input  logic [SEL_W-1:0]  sel_i,
  output logic [N_CH-1:0]   cmp_o,
  output logic [N_CH-1:0]   irq_o,
  output logic [CNT_W-1:0]  count_o,
  output logic              ovf_o
);

  logic [N_CH-1:0]  sync_q [SYNC_STAGES];
  logic [N_CH-1:0]  synced;
  logic [DEB_W-1:0] deb_q  [N_CH];
  logic [CNT_W-1:0] cnt_q  [N_CH];
  logic [N_CH-1:0]  ovf_q;
  logic [N_CH-1:0]  upd;
  logic [N_CH-1:0]  rise;
  logic [N_CH-1:0]  fall;
  logic [N_CH-1:0]  hit;
  logic [CNT_W-1:0] rd_cnt;
  logic             rd_ovf;

  assign synced = sync_q[SYNC_STAGES-1];

  always_ff @(posedge wb_clk_i or posedge wb_rst_i) begin
    if (wb_rst_i) begin
      for (int s = 0; s < SYNC_STAGES; s++)
        sync_q[s] <= '0;
    end else begin
      sync_q[0] <= cmp_i;
      for (int s = 1; s < SYNC_STAGES; s++)
        sync_q[s] <= sync_q[s-1];
    end
  end

  // upd marks the cycle the debounced level flips; events are derived
  // from it so irq/count update on the same edge as cmp_o.
  always_comb begin
    upd  = '0;
    rise = '0;
    fall = '0;
    hit  = '0;
    for (int i = 0; i < N_CH; i++) begin
      upd[i]  = enable_i && (synced[i] != cmp_o[i])
                && (deb_q[i] == deb_len_i);
      rise[i] = upd[i] & synced[i];
      fall[i] = upd[i] & ~synced[i];
      hit[i]  = (rise[i] & irq_mode_i[2*i])
              | (fall[i] & irq_mode_i[2*i+1]);
    end
  end

  always_ff @(posedge wb_clk_i or posedge wb_rst_i) begin
    if (wb_rst_i) begin
      cmp_o <= '0;
      for (int i = 0; i < N_CH; i++)
        deb_q[i] <= '0;
    end else begin
      for (int i = 0; i < N_CH; i++) begin
        if (!enable_i) begin
          deb_q[i] <= '0;
        end else if (synced[i] == cmp_o[i]) begin
          deb_q[i] <= '0;
        end else if (upd[i]) begin
          deb_q[i] <= '0;
          cmp_o[i] <= synced[i];
        end else begin
          deb_q[i] <= deb_q[i] + DEB_W'(1);
        end
      end
    end
  end

  // Set beats clear for irq; clear beats a rising event for the counter.
  always_ff @(posedge wb_clk_i or posedge wb_rst_i) begin
    if (wb_rst_i) begin
      irq_o <= '0;
      ovf_q <= '0;
      for (int i = 0; i < N_CH; i++)
        cnt_q[i] <= '0;
    end else begin
      for (int i = 0; i < N_CH; i++) begin
        if (hit[i])
          irq_o[i] <= 1'b1;
        else if (clear_i[i])
          irq_o[i] <= 1'b0;

        if (clear_i[i]) begin
          cnt_q[i] <= '0;
          ovf_q[i] <= 1'b0;
        end else if (rise[i]) begin
          if (&cnt_q[i])
            ovf_q[i] <= 1'b1;
          else
            cnt_q[i] <= cnt_q[i] + CNT_W'(1);
        end
      end
    end
  end

  // Out-of-range selects match no channel and read back zero.
  always_comb begin
    rd_cnt = '0;
    rd_ovf = 1'b0;
    for (int i = 0; i < N_CH; i++) begin
      if (sel_i == SEL_W'(i)) begin
        rd_cnt = cnt_q[i];
        rd_ovf = ovf_q[i];
      end
    end
  end

  always_ff @(posedge wb_clk_i or posedge wb_rst_i) begin
    if (wb_rst_i) begin
      count_o <= '0;
      ovf_o   <= 1'b0;
    end else begin
      count_o <= rd_cnt;
      ovf_o   <= rd_ovf;
    end
  end

endmodule

// File: tb/tb_comparator_monitor.sv
// Scoreboard bench for comparator_monitor: stimulus queues expected
// values, a negedge monitor pops and compares them against the DUT.
module tb_comparator_monitor;

  localparam int N_CH  = 4;
  localparam int CNT_W = 4;

  logic             clk;
  logic             rst;
  logic             enable;
  logic [N_CH-1:0]  cmp_in;
  logic [7:0]       deb_len;
  logic [7:0]       irq_mode;
  logic [N_CH-1:0]  clear;
  logic [1:0]       sel;
  logic [N_CH-1:0]  cmp_out;
  logic [N_CH-1:0]  irq;
  logic [CNT_W-1:0] count;
  logic             ovf;

  comparator_monitor #(
    .N_CH(N_CH),
    .SYNC_STAGES(2),
    .DEB_W(8),
    .CNT_W(CNT_W)
  ) dut (
    .wb_clk_i(clk),
    .wb_rst_i(rst),
    .enable_i(enable),
    .cmp_i(cmp_in),
    .deb_len_i(deb_len),
    .irq_mode_i(irq_mode),
    .clear_i(clear),
    .sel_i(sel),
    .cmp_o(cmp_out),
    .irq_o(irq),
    .count_o(count),
    .ovf_o(ovf)
  );

  typedef struct {
    string       name;
    int          kind;
    logic [31:0] mask;
    logic [31:0] exp;
  } exp_t;

  exp_t        sb[$];
  exp_t        e;
  logic [31:0] act;
  int          tests = 0;
  int          fails = 0;

  initial clk = 1'b0;
  always #5 clk = ~clk;

  localparam int K_CMP = 0;
  localparam int K_IRQ = 1;
  localparam int K_CNT = 2;
  localparam int K_OVF = 3;

  task automatic expect_v(input string name, input int kind,
                          input logic [31:0] mask,
                          input logic [31:0] exp);
    exp_t x;
    x.name = name;
    x.kind = kind;
    x.mask = mask;
    x.exp  = exp;
    sb.push_back(x);
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  always @(negedge clk) begin
    while (sb.size() > 0) begin
      e = sb.pop_front();
      case (e.kind)
        K_CMP:   act = 32'(cmp_out);
        K_IRQ:   act = 32'(irq);
        K_CNT:   act = 32'(count);
        default: act = 32'(ovf);
      endcase
      tests++;
      if ((act & e.mask) !== e.exp) begin
        fails++;
        $display("FAIL %s: got %0h want %0h",
                 e.name, act & e.mask, e.exp);
      end
    end
  end

  initial begin
    rst      = 1'b1;
    enable   = 1'b1;
    cmp_in   = '0;
    deb_len  = 8'd3;
    irq_mode = 8'b01_10_01_01;
    clear    = '0;
    sel      = 2'd0;
    #2;
    expect_v("rst_cmp", K_CMP, 32'hF, 32'h0);
    expect_v("rst_irq", K_IRQ, 32'hF, 32'h0);
    expect_v("rst_cnt", K_CNT, 32'hF, 32'h0);
    expect_v("rst_ovf", K_OVF, 32'h1, 32'h0);
    @(negedge clk);
    #1;
    rst = 1'b0;
    tick();
    tick();

    // latency: 2 sync + deb_len+1 = 6 edges
    cmp_in[0] = 1'b1;
    repeat (5) tick();
    expect_v("lat_early", K_CMP, 32'h1, 32'h0);
    tick();
    expect_v("lat_cmp", K_CMP, 32'h1, 32'h1);
    expect_v("lat_irq", K_IRQ, 32'h1, 32'h1);
    tick();
    expect_v("lat_cnt", K_CNT, 32'hF, 32'h1);

    // glitch of 3 cycles at deb_len 3
    cmp_in[1] = 1'b1;
    repeat (3) tick();
    cmp_in[1] = 1'b0;
    repeat (10) tick();
    sel = 2'd1;
    tick();
    tick();
    expect_v("gl_cmp", K_CMP, 32'h2, 32'h0);
    expect_v("gl_irq", K_IRQ, 32'h2, 32'h0);
    expect_v("gl_cnt", K_CNT, 32'hF, 32'h0);

    // falling-only mode on ch2, deb_len 0
    deb_len = 8'd0;
    sel = 2'd2;
    cmp_in[2] = 1'b1;
    repeat (10) tick();
    expect_v("md_cmp_hi", K_CMP, 32'h4, 32'h4);
    expect_v("md_irq_hi", K_IRQ, 32'h4, 32'h0);
    cmp_in[2] = 1'b0;
    repeat (10) tick();
    expect_v("md_cmp_lo", K_CMP, 32'h4, 32'h0);
    expect_v("md_irq_lo", K_IRQ, 32'h4, 32'h4);
    expect_v("md_cnt", K_CNT, 32'hF, 32'h1);

    // saturation on ch3
    sel = 2'd3;
    for (int p = 0; p < 15; p++) begin
      cmp_in[3] = 1'b1;
      repeat (4) tick();
      cmp_in[3] = 1'b0;
      repeat (4) tick();
    end
    expect_v("sat15_cnt", K_CNT, 32'hF, 32'hF);
    expect_v("sat15_ovf", K_OVF, 32'h1, 32'h0);
    for (int p = 0; p < 2; p++) begin
      cmp_in[3] = 1'b1;
      repeat (4) tick();
      cmp_in[3] = 1'b0;
      repeat (4) tick();
    end
    expect_v("sat17_cnt", K_CNT, 32'hF, 32'hF);
    expect_v("sat17_ovf", K_OVF, 32'h1, 32'h1);
    clear[3] = 1'b1;
    tick();
    clear[3] = 1'b0;
    tick();
    expect_v("clr_cnt", K_CNT, 32'hF, 32'h0);
    expect_v("clr_ovf", K_OVF, 32'h1, 32'h0);
    expect_v("clr_irq", K_IRQ, 32'h8, 32'h0);

    // clear on the rising-event cycle of ch0
    clear[0] = 1'b1;
    tick();
    clear[0] = 1'b0;
    cmp_in[0] = 1'b0;
    repeat (5) tick();
    expect_v("sim_fall_irq", K_IRQ, 32'h1, 32'h0);
    cmp_in[0] = 1'b1;
    repeat (2) tick();
    clear[0] = 1'b1;
    tick();
    clear[0] = 1'b0;
    expect_v("sim_cmp", K_CMP, 32'h1, 32'h1);
    expect_v("sim_irq", K_IRQ, 32'h1, 32'h1);
    sel = 2'd0;
    tick();
    tick();
    expect_v("sim_cnt", K_CNT, 32'hF, 32'h0);

    // enable low freezes the debounced level
    enable = 1'b0;
    cmp_in[1] = 1'b1;
    repeat (6) tick();
    expect_v("en_hold", K_CMP, 32'h2, 32'h0);
    enable = 1'b1;
    tick();
    expect_v("en_cmp", K_CMP, 32'h2, 32'h2);
    expect_v("en_irq", K_IRQ, 32'h2, 32'h2);

    // reset mid-debounce on ch3
    deb_len = 8'd3;
    cmp_in[3] = 1'b1;
    repeat (4) tick();
    rst = 1'b1;
    #1;
    expect_v("mr_cmp", K_CMP, 32'hF, 32'h0);
    expect_v("mr_irq", K_IRQ, 32'hF, 32'h0);
    expect_v("mr_cnt", K_CNT, 32'hF, 32'h0);
    expect_v("mr_ovf", K_OVF, 32'h1, 32'h0);
    @(negedge clk);
    #1;
    rst = 1'b0;
    repeat (5) tick();
    expect_v("mr_stale", K_CMP, 32'h8, 32'h0);
    tick();
    expect_v("mr_full", K_CMP, 32'h8, 32'h8);

    repeat (3) tick();
    if (sb.size() != 0) begin
      fails++;
      $display("FAIL drain: got %0d pending want 0", sb.size());
    end
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
